clk_sw_ctrl: RTL and testbench
==============================

CLK_SW_CTRL -- requirements
Module: clk_sw_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_SEL, default 0, meaning the clock-mux select value driven out of reset.
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the settle counter and of cfg_settle.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port gate_req  input  1  requested clock-gate enable while no switch is in progress.
REQ-006 SHALL have port sw_vld  input  1  switch request valid.
REQ-007 SHALL have port sw_sel  input  1  target mux select; sampled when the request is accepted.
REQ-008 SHALL have port sw_rdy  output  1  request may be accepted.
REQ-009 SHALL have port cfg_settle  input  CNT_W  settle count N; sampled when the request is accepted.
REQ-010 SHALL have port gate_en  output  1  registered enable to the downstream clock gate.
REQ-011 SHALL have port mux_sel  output  1  registered select to the downstream clock mux.
REQ-012 SHALL have port busy  output  1  high while the state is not IDLE.
REQ-013 SHALL have port sw_done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, GATE_OFF, SWITCH and GATE_ON.
REQ-015 SHALL drive sw_rdy = (state == IDLE), combinationally; a request is accepted on an edge where sw_vld and sw_rdy are both high.
REQ-016 In IDLE, SHALL register gate_en <= gate_req every cycle, giving one cycle of latency.
REQ-017 On acceptance with sw_sel == mux_sel, SHALL stay in IDLE, leave mux_sel unchanged, and pulse sw_done on the next cycle.
REQ-018 On acceptance with sw_sel != mux_sel, SHALL:
- latch the target and N;
- clear gate_en;
- load the counter with N;
- enter GATE_OFF.
REQ-019 In GATE_OFF, SWITCH and GATE_ON, SHALL decrement the counter each cycle; the state exits on the edge where the counter is 0, so each state lasts exactly N+1 cycles.
REQ-020 On the GATE_OFF exit, SHALL set mux_sel <= target, reload the counter with N, and enter SWITCH.
REQ-021 On the SWITCH exit, SHALL set gate_en <= gate_req, reload the counter with N, and enter GATE_ON.
REQ-022 On the GATE_ON exit, SHALL enter IDLE and assert sw_done for exactly one cycle.
REQ-023 For a switching request, sw_done SHALL rise 3*(N+1) cycles after the accept edge.
REQ-024 gate_en SHALL be 0 throughout GATE_OFF and SWITCH; a mux_sel change SHALL never coincide with gate_en = 1.
REQ-025 During GATE_ON, gate_en SHALL follow gate_req, registered.
REQ-026 sw_vld while busy SHALL be ignored (not queued); sw_sel and cfg_settle changes while busy SHALL have no effect.
REQ-027 N = 0 SHALL be legal, giving one cycle per state; N = 2^CNT_W-1 SHALL not wrap the counter.
REQ-028 A request accepted in the same cycle that sw_done is high SHALL be handled normally.

Reset
REQ-029 When rst = 1 at an edge, SHALL set, regardless of state (including mid-sequence):
- state = IDLE;
- mux_sel = DEFAULT_SEL;
- gate_en = 0;
- sw_done = 0;
- busy = 0;
- counter = 0.
REQ-030 sw_rdy SHALL read 1 in the first cycle after reset.
REQ-031 No request SHALL be accepted on an edge where rst = 1.

Verification
REQ-032 Reset, then gate_req = 1 -> gate_en = 0 in the first cycle, 1 one cycle later; mux_sel = 0.
REQ-033 N = 2, sw_sel = 1 accepted -> gate_en = 0 for 6 cycles, mux_sel goes 0 to 1 after cycle 3 while gate_en = 0, sw_done pulses at cycle 9, busy low from cycle 9.
REQ-034 N = 0, sw_sel equal to the current mux_sel -> busy stays 0, sw_done pulses on the next cycle, gate_en unchanged.
REQ-035 sw_vld held high during a sequence with sw_sel toggling -> exactly one switch occurs; the next acceptance happens only in IDLE.
REQ-036 rst asserted in the SWITCH state -> next cycle mux_sel = DEFAULT_SEL, gate_en = 0, busy = 0, sw_done never pulses.
REQ-037 N = 15 (CNT_W = 4) -> each state lasts 16 cycles, sw_done at cycle 48.

Source files
------------

// File: rtl/clk_sw_ctrl.sv
// Glitch-free clock switch sequencer: gate off, move the mux, gate back on,
// with a programmable settle time in each phase.
module clk_sw_ctrl #(
    parameter bit DEFAULT_SEL = 1'b0,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate_req,
    input  logic             sw_vld,
    input  logic             sw_sel,
    output logic             sw_rdy,
    input  logic [CNT_W-1:0] cfg_settle,
    output logic             gate_en,
    output logic             mux_sel,
    output logic             busy,
    output logic             sw_done
);

    typedef enum logic [1:0] {
        IDLE,
        GATE_OFF,
        SWITCH,
        GATE_ON
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] n_q, n_nx;
    logic             tgt, tgt_nx;
    logic             gate_nx;
    logic             mux_nx;
    logic             done_nx;
    logic             last;
    logic             accept;

    assign sw_rdy = (state == IDLE);
    assign busy   = (state != IDLE);
    assign accept = sw_vld && sw_rdy;
    assign last   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            n_q     <= '0;
            tgt     <= DEFAULT_SEL;
            gate_en <= 1'b0;
            mux_sel <= DEFAULT_SEL;
            sw_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            n_q     <= n_nx;
            tgt     <= tgt_nx;
            gate_en <= gate_nx;
            mux_sel <= mux_nx;
            sw_done <= done_nx;
        end
    end

    // Counter is tested for zero before decrementing, so it never wraps.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_nx     = n_q;
        tgt_nx   = tgt;
        gate_nx  = gate_en;
        mux_nx   = mux_sel;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                gate_nx = gate_req;
                if (accept) begin
                    if (sw_sel == mux_sel) begin
                        done_nx = 1'b1;
                    end else begin
                        tgt_nx   = sw_sel;
                        n_nx     = cfg_settle;
                        cnt_nx   = cfg_settle;
                        gate_nx  = 1'b0;
                        state_nx = GATE_OFF;
                    end
                end
            end
            GATE_OFF: begin
                gate_nx = 1'b0;
                if (last) begin
                    mux_nx   = tgt;
                    cnt_nx   = n_q;
                    state_nx = SWITCH;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            SWITCH: begin
                if (last) begin
                    gate_nx  = gate_req;
                    cnt_nx   = n_q;
                    state_nx = GATE_ON;
                end else begin
                    gate_nx = 1'b0;
                    cnt_nx  = cnt - 1'b1;
                end
            end
            GATE_ON: begin
                gate_nx = gate_req;
                if (last) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Randomised bench for clk_sw_ctrl against a phase-age reference model.
// Scenario tasks each compare DUT outputs with the model inline.
module tb_clk_sw_ctrl;

    localparam bit DEF = 1'b0;
    localparam int W   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         gate_req = 1'b0;
    logic         sw_vld = 1'b0;
    logic         sw_sel = 1'b0;
    logic [W-1:0] cfg_settle = '0;
    logic         sw_rdy;
    logic         gate_en;
    logic         mux_sel;
    logic         busy;
    logic         sw_done;

    int checks = 0;
    int failures = 0;

    // Reference model: a switch is described only by its age in cycles
    // since acceptance and the settle count; phases follow from arithmetic.
    bit e_ge = 1'b0;
    bit e_mux = DEF;
    bit e_done = 1'b0;
    bit act = 1'b0;
    bit tgt = 1'b0;
    int m = 0;
    int nn = 0;

    clk_sw_ctrl #(.DEFAULT_SEL(DEF), .CNT_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .gate_req(gate_req),
        .sw_vld(sw_vld),
        .sw_sel(sw_sel),
        .sw_rdy(sw_rdy),
        .cfg_settle(cfg_settle),
        .gate_en(gate_en),
        .mux_sel(mux_sel),
        .busy(busy),
        .sw_done(sw_done)
    );

    always #5 clk = ~clk;

    function automatic bit e_busy();
        return act && (m < 3 * (nn + 1));
    endfunction

    task automatic tick();
        bit b;
        @(posedge clk);
        b = e_busy();
        e_done = 1'b0;
        if (rst) begin
            act = 1'b0;
            m = 0;
            e_mux = DEF;
            e_ge = 1'b0;
        end else if (!b) begin
            e_ge = gate_req;
            if (sw_vld) begin
                if (sw_sel == e_mux) begin
                    e_done = 1'b1;
                end else begin
                    act = 1'b1;
                    m = 0;
                    nn = int'(cfg_settle);
                    tgt = sw_sel;
                    e_ge = 1'b0;
                end
            end
        end else begin
            m++;
            if (m == nn + 1) e_mux = tgt;
            e_ge = (m >= 2 * (nn + 1)) ? gate_req : 1'b0;
            if (m == 3 * (nn + 1)) e_done = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gate_req = 1'b1;
        sw_vld = 1'b1;
        sw_sel = ~DEF;
        tick();
        tick();
        sw_vld = 1'b0;
        checks++;
        if ({gate_en, mux_sel, busy, sw_done, sw_rdy} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00001",
                     {gate_en, mux_sel, busy, sw_done, sw_rdy});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gate_en !== 1'b1 || mux_sel !== DEF) begin
            failures++;
            $display("FAIL reset_gate_latency got=%b%b exp=1%b",
                     gate_en, mux_sel, DEF);
        end
    endtask

    task automatic test_switch_n2();
        int done_at;
        bit pm;
        done_at = -1;
        sw_vld = 1'b1;
        sw_sel = ~e_mux;
        cfg_settle = 4'd2;
        gate_req = 1'b1;
        tick();
        sw_vld = 1'b0;
        pm = mux_sel;
        for (int k = 1; k <= 14; k++) begin
            gate_req = 1'($urandom);
            tick();
            checks++;
            if ({gate_en, mux_sel, busy, sw_done}
                !== {e_ge, e_mux, e_busy(), e_done}) begin
                failures++;
                $display("FAIL n2_cycle%0d got=%b exp=%b", k,
                         {gate_en, mux_sel, busy, sw_done},
                         {e_ge, e_mux, e_busy(), e_done});
            end
            if (mux_sel !== pm && gate_en !== 1'b0) begin
                failures++;
                $display("FAIL n2_mux_gate got=%b exp=0", gate_en);
            end
            pm = mux_sel;
            if (sw_done === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (done_at != 9) begin
            failures++;
            $display("FAIL n2_done_time got=%0d exp=9", done_at);
        end
    endtask

    task automatic test_same_sel();
        bit g;
        cfg_settle = 4'd0;
        gate_req = 1'b1;
        tick();
        g = gate_en;
        sw_vld = 1'b1;
        sw_sel = e_mux;
        tick();
        sw_vld = 1'b0;
        checks++;
        if ({sw_done, busy, gate_en, mux_sel} !== {2'b10, g, e_mux}) begin
            failures++;
            $display("FAIL same_sel got=%b exp=%b",
                     {sw_done, busy, gate_en, mux_sel}, {2'b10, g, e_mux});
        end
        tick();
        checks++;
        if (sw_done !== 1'b0) begin
            failures++;
            $display("FAIL same_sel_pulse got=%b exp=0", sw_done);
        end
    endtask

    task automatic test_held_vld();
        int changes;
        int n;
        bit pm;
        changes = 0;
        n = int'($urandom_range(0, 3));
        cfg_settle = 4'(n);
        sw_vld = 1'b1;
        sw_sel = ~e_mux;
        tick();
        pm = mux_sel;
        for (int k = 1; k <= 3 * (n + 1); k++) begin
            sw_sel = ~sw_sel;
            cfg_settle = 4'($urandom);
            gate_req = 1'($urandom);
            tick();
            checks++;
            if ({gate_en, mux_sel, busy, sw_done}
                !== {e_ge, e_mux, e_busy(), e_done}) begin
                failures++;
                $display("FAIL held_cycle%0d got=%b exp=%b", k,
                         {gate_en, mux_sel, busy, sw_done},
                         {e_ge, e_mux, e_busy(), e_done});
            end
            if (mux_sel !== pm) changes++;
            pm = mux_sel;
        end
        sw_vld = 1'b0;
        checks++;
        if (changes != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL held_one_switch got=%0d/%b exp=1/0",
                     changes, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        cfg_settle = 4'd3;
        sw_vld = 1'b1;
        sw_sel = ~e_mux;
        tick();
        sw_vld = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mux_sel, gate_en, busy, sw_done} !== {DEF, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b",
                     {mux_sel, gate_en, busy, sw_done}, {DEF, 3'b000});
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sw_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_n_max();
        int done_at;
        done_at = -1;
        cfg_settle = 4'd15;
        sw_vld = 1'b1;
        sw_sel = ~e_mux;
        tick();
        sw_vld = 1'b0;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            gate_req = 1'($urandom);
            tick();
            if ({gate_en, mux_sel, busy, sw_done}
                !== {e_ge, e_mux, e_busy(), e_done}) begin
                failures++;
                $display("FAIL nmax_cycle%0d got=%b exp=%b", k,
                         {gate_en, mux_sel, busy, sw_done},
                         {e_ge, e_mux, e_busy(), e_done});
            end
            if (sw_done === 1'b1) done_at = k;
        end
        checks++;
        if (done_at != 48) begin
            failures++;
            $display("FAIL nmax_done_time got=%0d exp=48", done_at);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        bit orig;
        seen = 1'b0;
        orig = e_mux;
        cfg_settle = 4'd1;
        sw_vld = 1'b1;
        sw_sel = ~orig;
        tick();
        sw_sel = orig;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = (sw_done === 1'b1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_first_done got=0 exp=1");
        end
        tick();
        sw_vld = 1'b0;
        checks++;
        if ({busy, mux_sel, gate_en} !== {e_busy(), e_mux, e_ge}
            || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_accept got=%b exp=1%b%b",
                     {busy, mux_sel, gate_en}, e_mux, e_ge);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({gate_en, mux_sel, busy, sw_done}
                !== {e_ge, e_mux, e_busy(), e_done}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%b exp=%b", k,
                         {gate_en, mux_sel, busy, sw_done},
                         {e_ge, e_mux, e_busy(), e_done});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            gate_req = 1'($urandom);
            sw_vld = ($urandom_range(0, 3) == 0);
            sw_sel = 1'($urandom);
            cfg_settle = 4'($urandom_range(0, 3));
            tick();
            checks++;
            if ({gate_en, mux_sel, busy, sw_done, sw_rdy}
                !== {e_ge, e_mux, e_busy(), e_done, !e_busy()}) begin
                failures++;
                $display("FAIL random_cycle%0d got=%b exp=%b", k,
                         {gate_en, mux_sel, busy, sw_done, sw_rdy},
                         {e_ge, e_mux, e_busy(), e_done, !e_busy()});
            end
        end
        rst = 1'b0;
        sw_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_switch_n2();
        test_same_sel();
        test_held_vld();
        test_reset_mid();
        test_n_max();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
